wb_forward_tracker: RTL
=======================

# wb_forward_tracker

Producer side of the EX/MEM/WB operand-forwarding path. Tracks the two youngest in-flight register writes (MEM and WB stages) and presents each as an rd/value pair for the ID-stage bypass mux. Raises a load-use stall when a load's data is not yet available, and drives the register-file write port from the WB stage.

## Interface
- XLEN, 32, data width
- REG_AW, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  EX stage holds a real instruction
- ex_reg_write  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  REG_AW  EX destination register
- ex_alu_result  in  XLEN  EX result for non-loads
- ex_flush  in  1  squash the EX instruction this cycle (branch redirect)
- mem_load_data  in  XLEN  load data for the instruction in the MEM slot, valid same cycle
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- fwd_rd_1, fwd_val_1  out  REG_AW/XLEN  MEM-slot (youngest) forwarding pair
- fwd_rd_2, fwd_val_2  out  REG_AW/XLEN  WB-slot (older) forwarding pair
- load_use_stall  out  1  hold IF/ID and inject a bubble into EX
- rf_we, rf_waddr, rf_wdata  out  1/REG_AW/XLEN  register-file write port

## Operation
- Two registered slots: M (MEM stage) and W (WB stage). Each slot holds valid, is_load, rd, and value.
- Capture into M on every edge:
  - valid = ex_valid & ex_reg_write & ~ex_flush & (ex_rd != 0)
  - value = ex_alu_result
  - An x0 destination is never tracked.
- M → W on every edge. W.value = M.is_load ? mem_load_data : M.value.
- No internal pipeline hold. Upstream inserts the bubble during a stall (ex_valid = 0).
- Forwarding outputs:
  - Slot 1 = M if M.valid & ~M.is_load.
  - Slot 2 = W if W.valid.
  - Any slot not presented drives rd = 0 and value = 0, so the consumer's x0 match yields 0.
- load_use_stall = M.valid & M.is_load & (M.rd == id_rs1 | M.rd == id_rs2). Combinational from registered state plus id_rs*.
- Register-file write: rf_we = W.valid, rf_waddr = W.rd, rf_wdata = W.value. When W is invalid, rf_waddr and rf_wdata are 0.
- Both slots valid with the same rd: both are presented. The consumer gives slot 1 priority, so the youngest value wins.

## Timing
- Reset (async, immediate): both slots invalid with rd, value and is_load cleared. All outputs are 0, including load_use_stall.
- Latency:
  - ALU result in EX at cycle N: visible on slot 1 in N+1, on slot 2 and the RF port in N+2.
  - Load in EX at cycle N: stall asserted in N+1 if ID depends on it. Data is on slot 2 and the RF port in N+2. Stall is exactly one cycle.
- ex_flush has priority over ex_valid in the same cycle. It affects only the EX capture; M and W continue.
- Reset mid-pipeline discards both slots with no RF write. Release is synchronous to the next clk edge.

## Structure
- Shared package: XLEN, REG_AW, and a packed slot typedef {valid, is_load, rd, value}. The same slot type feeds the consumer bypass mux.
- Single module. The slot is a plain register with no sub-module.

## Test plan
- Reset asserted mid-stream with both slots valid → every output 0 immediately; no rf_we after release.
- ALU op x5 = 0x1234 in EX at cycle N:
  - fwd_rd_1 = 5 and fwd_val_1 = 0x1234 at N+1.
  - fwd_rd_2 = 5, rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234 at N+2.
- Load to x7 at N, id_rs2 = 7 at N+1, mem_load_data = 0xCAFEF00D at N+1:
  - load_use_stall = 1 only at N+1.
  - fwd_rd_1 = 0 at N+1.
  - fwd_rd_2 = 7 and fwd_val_2 = 0xCAFEF00D at N+2.
- Back-to-back writes to x3 (0xA, then 0xB) → at the second's N+1, slot 1 = (3, 0xB) and slot 2 = (3, 0xA).
- Writes with rd = 0, ex_reg_write = 0, or ex_flush = 1 → no slot valid, no rf_we, no stall even if id_rs1 matches.

Source files
------------

// File: rtl/wb_forward_tracker_pkg.sv
// Shared types for the EX/MEM/WB forwarding path: data widths and the
// packed in-flight write slot consumed by the ID-stage bypass mux.
package wb_forward_tracker_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic              is_load;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   value;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{
        valid:   1'b0,
        is_load: 1'b0,
        rd:      {REG_AW{1'b0}},
        value:   {XLEN{1'b0}}
    };

    // True when the slot carries a live write whose rd matches the given source register.
    function automatic logic slot_matches(input slot_t s, input logic [REG_AW-1:0] rs);
        return s.valid & (s.rd == rs);
    endfunction

endpackage

// File: rtl/wb_forward_tracker_if.sv
// Bundle of EX capture inputs, ID source registers, forwarding pairs and the
// register-file write port; master drives the pipeline side, slave is the tracker.
interface wb_forward_tracker_if;
    import wb_forward_tracker_pkg::*;

    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic [XLEN-1:0]   ex_alu_result;
    logic              ex_flush;
    logic [XLEN-1:0]   mem_load_data;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] fwd_rd_1;
    logic [XLEN-1:0]   fwd_val_1;
    logic [REG_AW-1:0] fwd_rd_2;
    logic [XLEN-1:0]   fwd_val_2;
    logic              load_use_stall;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    modport master (
        output ex_valid, ex_reg_write, ex_is_load, ex_rd, ex_alu_result, ex_flush,
        output mem_load_data, id_rs1, id_rs2,
        input  fwd_rd_1, fwd_val_1, fwd_rd_2, fwd_val_2, load_use_stall,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  ex_valid, ex_reg_write, ex_is_load, ex_rd, ex_alu_result, ex_flush,
        input  mem_load_data, id_rs1, id_rs2,
        output fwd_rd_1, fwd_val_1, fwd_rd_2, fwd_val_2, load_use_stall,
        output rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/wb_forward_tracker.sv
// Tracks the MEM and WB in-flight register writes, presents them as bypass
// pairs, flags load-use hazards and drives the register-file write port.
module wb_forward_tracker
    import wb_forward_tracker_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    wb_forward_tracker_if.slave  bus
);

    slot_t m_slot_r;
    slot_t w_slot_r;
    slot_t m_next_s;
    slot_t w_next_s;

    // Next-state of both slots: EX capture into M, M advancing into W with load data merged.
    always_comb begin
        m_next_s         = SLOT_EMPTY;
        m_next_s.valid   = bus.ex_valid & bus.ex_reg_write & ~bus.ex_flush
                           & (bus.ex_rd != {REG_AW{1'b0}});
        m_next_s.is_load = bus.ex_is_load;
        m_next_s.rd      = bus.ex_rd;
        m_next_s.value   = bus.ex_alu_result;

        w_next_s = m_slot_r;
        if (m_slot_r.is_load) begin
            w_next_s.value = bus.mem_load_data;
        end else begin
            w_next_s.value = m_slot_r.value;
        end
    end

    // Slot registers; reset discards both in-flight writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_slot_r <= SLOT_EMPTY;
            w_slot_r <= SLOT_EMPTY;
        end else begin
            m_slot_r <= m_next_s;
            w_slot_r <= w_next_s;
        end
    end

    // Forwarding pairs, hazard flag and RF port; hidden slots read as x0 so they forward 0.
    always_comb begin
        bus.fwd_rd_1       = {REG_AW{1'b0}};
        bus.fwd_val_1      = {XLEN{1'b0}};
        bus.fwd_rd_2       = {REG_AW{1'b0}};
        bus.fwd_val_2      = {XLEN{1'b0}};
        bus.rf_we          = 1'b0;
        bus.rf_waddr       = {REG_AW{1'b0}};
        bus.rf_wdata       = {XLEN{1'b0}};
        bus.load_use_stall = m_slot_r.is_load
                             & (slot_matches(m_slot_r, bus.id_rs1)
                                | slot_matches(m_slot_r, bus.id_rs2));

        // A load in M has no data yet, so only ALU results are bypassed from M.
        if (m_slot_r.valid & ~m_slot_r.is_load) begin
            bus.fwd_rd_1  = m_slot_r.rd;
            bus.fwd_val_1 = m_slot_r.value;
        end else begin
            bus.fwd_rd_1  = {REG_AW{1'b0}};
            bus.fwd_val_1 = {XLEN{1'b0}};
        end

        if (w_slot_r.valid) begin
            bus.fwd_rd_2  = w_slot_r.rd;
            bus.fwd_val_2 = w_slot_r.value;
            bus.rf_we     = 1'b1;
            bus.rf_waddr  = w_slot_r.rd;
            bus.rf_wdata  = w_slot_r.value;
        end else begin
            bus.fwd_rd_2  = {REG_AW{1'b0}};
            bus.fwd_val_2 = {XLEN{1'b0}};
            bus.rf_we     = 1'b0;
            bus.rf_waddr  = {REG_AW{1'b0}};
            bus.rf_wdata  = {XLEN{1'b0}};
        end
    end

endmodule
